// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, types and helpers for the 3x3 convolution stage
// Purpose: datapath widths, tap indexing, identity-kernel constant and u8 clamp.
// Ports: none (package).
package conv_pkg;

    localparam int PIX_W      = 8;
    localparam int COEF_W     = 8;
    localparam int PROD_W     = 17;
    localparam int SUM_W      = 21;
    localparam int NTAPS      = 9;
    localparam int CENTRE_TAP = 4;

    typedef logic        [PIX_W-1:0]  pix_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    // Identity kernel: unity gain at the centre tap once the result is
    // shifted right by 'shift'.
    function automatic coef_t identity_coef(input int tap, input int shift);
        return (tap == CENTRE_TAP) ? coef_t'(1 << shift) : '0;
    endfunction

    // Saturate a signed sum to the unsigned 8-bit pixel range.
    function automatic pix_t clamp_u8(input sum_t v);
        if (v[SUM_W-1])
            return '0;
        else if (|v[SUM_W-2:PIX_W])
            return '1;
        else
            return v[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - DEPTH-deep pixel delay line with shift enable
// Purpose: returns the pixel written DEPTH enabled cycles earlier (one row up).
// Ports:
//   clk    - clock, rising edge
//   en_i   - shift enable (pixel accepted)
//   din_i  - pixel entering the line
//   dout_o - pixel leaving the line
// Contents are not reset; the consumer gates stale data by row/column.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic en_i,
    input  pix_t din_i,
    output pix_t dout_o
);

    pix_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv3x3_stage.sv
// rtl/conv3x3_stage.sv - 3x3 signed-kernel convolution over a raster pixel stream
// Purpose: windowing via two line buffers, 9 products, sum, shift, clamp.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   start, pix_valid    - a pixel is accepted when both are high
//   pix_in              - unsigned 8-bit pixel, raster order
//   k_we/k_addr/k_data  - coefficient write port (taps 0..8, row-major)
//   pix_out             - clamped result, qualified by out_valid
//   out_valid           - result valid, 3 clocks after the completing accept
//   frame_done          - pulses with the last result of a frame
module conv3x3_stage
    import conv_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int SHIFT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pix_valid,
    input  logic [7:0] pix_in,
    input  logic       k_we,
    input  logic [3:0] k_addr,
    input  logic [7:0] k_data,
    output logic [7:0] pix_out,
    output logic       out_valid,
    output logic       frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic          accept;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    pix_t          lb0_out, lb1_out;

    pix_t  win_q  [NTAPS];   // index = row*3 + col, row 0 / col 0 oldest
    coef_t coef_q [NTAPS];
    prod_t prod_q [NTAPS];
    sum_t  sum_q, sum_d;
    pix_t  pix_out_q;

    logic win_vld_d, win_last_d;
    logic v0_q, l0_q, v1_q, l1_q, v2_q, l2_q;
    logic out_valid_q, frame_done_q;

    // Coefficient writes land one edge late so that a window accepted on the
    // same edge as a write still multiplies by the old coefficient.
    logic       kw_q;
    logic [3:0] ka_q;
    coef_t      kd_q;

    assign accept = start & pix_valid;

    conv_line_buffer #(.DEPTH(IMG_W)) u_lb0 (
        .clk    (clk),
        .en_i   (accept),
        .din_i  (pix_in),
        .dout_o (lb0_out)
    );

    conv_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
        .clk    (clk),
        .en_i   (accept),
        .din_i  (lb0_out),
        .dout_o (lb1_out)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == CW'(IMG_W-1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H-1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    assign win_vld_d  = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign win_last_d = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NTAPS; i++) begin
            sum_d = sum_d + sum_t'(prod_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                win_q[i]  <= '0;
                coef_q[i] <= identity_coef(i, SHIFT);
                prod_q[i] <= '0;
            end
            sum_q        <= '0;
            pix_out_q    <= '0;
            v0_q         <= 1'b0;
            l0_q         <= 1'b0;
            v1_q         <= 1'b0;
            l1_q         <= 1'b0;
            v2_q         <= 1'b0;
            l2_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            kw_q         <= 1'b0;
            ka_q         <= '0;
            kd_q         <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;

            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r*3]   <= win_q[r*3+1];
                    win_q[r*3+1] <= win_q[r*3+2];
                end
                win_q[2] <= lb1_out;
                win_q[5] <= lb0_out;
                win_q[8] <= pix_in;
            end
            v0_q <= win_vld_d;
            l0_q <= win_vld_d & win_last_d;

            // S1: unsigned pixel zero-extended, then signed multiply.
            for (int i = 0; i < NTAPS; i++) begin
                prod_q[i] <= prod_t'($signed({1'b0, win_q[i]})) * prod_t'(coef_q[i]);
            end
            v1_q <= v0_q;
            l1_q <= l0_q;

            // S2
            sum_q <= sum_d;
            v2_q  <= v1_q;
            l2_q  <= l1_q;

            // S3: floor shift then saturate; hold the last result on bubbles.
            if (v2_q) begin
                pix_out_q <= clamp_u8(sum_q >>> SHIFT);
            end
            out_valid_q  <= v2_q;
            frame_done_q <= l2_q;

            kw_q <= k_we && (k_addr <= 4'd8);
            ka_q <= k_addr;
            kd_q <= coef_t'(k_data);
            for (int i = 0; i < NTAPS; i++) begin
                if (kw_q && (ka_q == 4'(i))) begin
                    coef_q[i] <= kd_q;
                end
            end
        end
    end

    assign pix_out    = pix_out_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv3x3_stage.sv
// tb/tb_conv3x3_stage.sv - self-checking bench for conv3x3_stage
module tb_conv3x3_stage;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int SH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pix_valid;
    logic [7:0] pix_in;
    logic       k_we;
    logic [3:0] k_addr;
    logic [7:0] k_data;
    logic [7:0] pix_out;
    logic       out_valid;
    logic       frame_done;

    always #5 clk = ~clk;

    conv3x3_stage #(.IMG_W(W), .IMG_H(H), .SHIFT(SH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pix_valid  (pix_valid),
        .pix_in     (pix_in),
        .k_we       (k_we),
        .k_addr     (k_addr),
        .k_data     (k_data),
        .pix_out    (pix_out),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    typedef struct {
        int val;
        bit last;
        int due;
    } exp_t;

    typedef struct {
        int k[9];
        int bg;
        int ctr;
        int expv;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t tv[6];

    int total   = 0;
    int bad     = 0;
    int edges   = 0;
    int fd_seen = 0;
    int ovr     = -1;
    bit mon_en  = 1'b0;

    int img[H][W];
    int kc[9];

    int IDN[9]  = '{0, 0, 0, 0, 16, 0, 0, 0, 0};
    int ONES[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    int LAP[9]  = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
    int C127[9] = '{0, 0, 0, 0, 127, 0, 0, 0, 0};
    int C1[9]   = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

    always @(posedge clk) edges++;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, edges);
        end
    endtask

    // Reference result for the window centred on (r, c).
    function automatic int model(input int r, input int c);
        int s = 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                s += kc[dr*3+dc] * img[r-1+dr][c-1+dc];
        s = s >>> SH;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got pix %0d, expected no output (edge %0d)", pix_out, edges);
                end else begin
                    mon_e = sbq.pop_front();
                    check("pix", int'(pix_out), mon_e.val);
                    check("frame_done", int'(frame_done), int'(mon_e.last));
                    check("latency", edges, mon_e.due);
                end
                if (frame_done) fd_seen++;
            end else if (frame_done) begin
                total++;
                bad++;
                $display("FAIL stray_frame_done: got 1 without out_valid, expected 0 (edge %0d)", edges);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_pix(input int r, input int c, input int v,
                             input bit kw, input int ka, input int kd);
        start     = 1'b1;
        pix_valid = 1'b1;
        pix_in    = 8'(v);
        k_we      = kw;
        k_addr    = 4'(ka);
        k_data    = 8'(kd);
        @(posedge clk);
        #1;
        if (r >= 2 && c >= 2) begin
            exp_t e;
            e.val  = (ovr >= 0 && r == 4 && c == 4) ? ovr : model(r-1, c-1);
            e.last = (r == H-1) && (c == W-1);
            e.due  = edges + 3;
            sbq.push_back(e);
        end
        pix_valid = 1'b0;
        k_we      = 1'b0;
    endtask

    task automatic stream_frame(input int gap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                drive_pix(r, c, img[r][c], 1'b0, 0, 0);
                idle(gap);
            end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() > 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", sbq.size(), 0);
        sbq.delete();
        idle(2);
    endtask

    task automatic load_kernel(input int k[9]);
        for (int i = 0; i < 9; i++) begin
            k_we   = 1'b1;
            k_addr = 4'(i);
            k_data = 8'(k[i]);
            @(posedge clk);
            #1;
        end
        k_we = 1'b0;
        kc   = k;
        idle(1);
    endtask

    task automatic set_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8*r + c;
    endtask

    task automatic set_uniform(input int bg, input int ctr);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = bg;
        img[3][3] = ctr;
    endtask

    task automatic ramp_frame(input int gap);
        set_ramp();
        fd_seen = 0;
        stream_frame(gap);
        wait_drain();
        check("fd_count", fd_seen, 1);
    endtask

    initial begin
        tv[0].k = ONES; tv[0].bg = 255; tv[0].ctr = 255; tv[0].expv = 143;
        tv[1].k = LAP;  tv[1].bg = 255; tv[1].ctr = 0;   tv[1].expv = 0;
        tv[2].k = C127; tv[2].bg = 255; tv[2].ctr = 255; tv[2].expv = 255;
        tv[3].k = IDN;  tv[3].bg = 100; tv[3].ctr = 37;  tv[3].expv = 37;
        tv[4].k = LAP;  tv[4].bg = 10;  tv[4].ctr = 50;  tv[4].expv = 20;
        tv[5].k = C1;   tv[5].bg = 0;   tv[5].ctr = 31;  tv[5].expv = 1;

        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = '0;
        k_we = 1'b0; k_addr = '0; k_data = '0;
        idle(2);
        check("rst_pix_out", int'(pix_out), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_frame_done", int'(frame_done), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        idle(1);

        // Reset kernel must already be identity.
        kc = IDN;
        ramp_frame(0);

        // Sparse pixel strobes.
        ramp_frame(20);

        // Out-of-range coefficient writes must be ignored.
        for (int a = 9; a < 16; a++) begin
            k_we = 1'b1; k_addr = 4'(a); k_data = 8'(8'h41 + a);
            idle(1);
        end
        k_we = 1'b0;
        idle(1);

        // pix_valid without start is not accepted.
        start = 1'b0;
        pix_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pix_in = 8'($urandom_range(0, 255));
            idle(1);
        end
        pix_valid = 1'b0;
        ramp_frame(0);

        // Table-driven kernels with a single distinct centre pixel.
        for (int t = 0; t < 6; t++) begin
            load_kernel(tv[t].k);
            set_uniform(tv[t].bg, tv[t].ctr);
            ovr = tv[t].expv;
            fd_seen = 0;
            stream_frame(0);
            wait_drain();
            check("vec_fd_count", fd_seen, 1);
            ovr = -1;
        end

        // Coefficient write on the same edge as an accept: that window keeps
        // the old kernel, later windows see the new one.
        load_kernel(IDN);
        set_ramp();
        fd_seen = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (r == 4 && c == 4) begin
                    drive_pix(r, c, img[r][c], 1'b1, 4, 32);
                    kc[4] = 32;
                end else begin
                    drive_pix(r, c, img[r][c], 1'b0, 0, 0);
                end
            end
        wait_drain();
        check("kw_fd_count", fd_seen, 1);

        // Mid-frame reset with a non-identity kernel loaded.
        load_kernel(ONES);
        set_ramp();
        for (int i = 0; i < 30; i++)
            drive_pix(i / W, i % W, img[i / W][i % W], 1'b0, 0, 0);
        rst = 1'b1;
        idle(1);
        sbq.delete();
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_frame_done", int'(frame_done), 0);
        check("midrst_pix_out", int'(pix_out), 0);
        rst = 1'b0;
        kc = IDN;
        idle(8);
        ramp_frame(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule

// File: doc/conv3x3_stage.md
Name: conv3x3_stage

Overview:
Downstream consumer of the pixel shift stage. Takes its 8-bit raster pixel stream, builds a 3x3 window with two internal line buffers, and applies a programmable signed 3x3 kernel. Results are normalised by a right shift and clamped to 8-bit. Outputs are "valid-region" only: (IMG_W-2)*(IMG_H-2) pixels per frame, with a valid strobe and an end-of-frame pulse.

Parameters:
IMG_W, 8, pixels per image row (>=3)
IMG_H, 8, rows per frame (>=3)
SHIFT, 4, arithmetic right shift applied to the accumulated sum

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  enable; pixels are accepted only while high
pix_valid  in  1  pixel strobe from upstream shift stage
pix_in  in  8  unsigned pixel, raster order
k_we  in  1  kernel coefficient write strobe
k_addr  in  4  coefficient index 0..8, row-major (0 = top-left = oldest row/column)
k_data  in  8  signed two's-complement coefficient
pix_out  out  8  clamped convolution result
out_valid  out  1  pix_out valid this cycle
frame_done  out  1  one-cycle pulse with the last output pixel of a frame

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high.
- Reset: pix_out=0, out_valid=0, frame_done=0; col/row counters=0; all pipeline valid bits=0; window regs=0; kernel = identity (coeff[4]=1<<SHIFT, others 0). Line-buffer contents are don't-care.
- Accept: pixel accepted on an edge where start=1 and pix_valid=1. Otherwise counters, line buffers and window hold. The pipeline does not stall; bubbles propagate as out_valid=0.
- Per accepted pixel:
  - shift window left;
  - new column = {linebuf1 out, linebuf0 out, pix_in};
  - linebuf0 <= pix_in; linebuf1 <= linebuf0 out;
  - col++, wrapping at IMG_W-1 to 0 with row++; row wraps at IMG_H-1 to 0 (next frame).
- Window is valid when the accepted pixel has row>=2 and col>=2. The result corresponds to the centre (row-1, col-1). Row/col gating makes stale line-buffer data from a previous frame irrelevant.
- Pipeline (3 register stages):
  - S1: 9 signed products, unsigned pixel x signed coeff, 17-bit signed.
  - S2: 21-bit signed sum.
  - S3: arithmetic shift right by SHIFT (floor), then clamp: <0 -> 0, >255 -> 255.
- Latency: out_valid is asserted exactly 3 clocks after the accepting edge of the window-completing pixel.
- frame_done: asserted with out_valid of the pixel accepted at (IMG_H-1, IMG_W-1).
- Kernel write: on an edge with k_we=1, coeff[k_addr] <= k_data; k_addr>8 is ignored. The new coefficient is used by windows accepted on later edges. Writes mid-frame are legal but are not frame-atomic.
- Simultaneous k_we and pixel accept: the accepted pixel uses the old coefficient.
- rst mid-frame: all in-flight results are dropped (no out_valid after the reset edge), counters return to 0, the kernel returns to identity. The next accepted pixel is treated as (0,0).

Decomposition:
- conv_pkg:
  - constants PIX_W=8, COEF_W=8, PROD_W=17, SUM_W=21;
  - identity-kernel constant;
  - clamp-to-u8 function.
- One sub-module, conv_line_buffer: IMG_W-deep 8-bit delay line with enable. Instantiated twice.

Test Plan:
1. Identity kernel, 8x8 ramp pix=8*r+c streamed back-to-back -> 36 outputs 9,10..14,17..54 in raster order; first out_valid 3 clocks after the 19th pixel is accepted; frame_done coincides with value 54.
2. All coeffs 1, constant 255 image -> 9*255=2295>>4 = 143 on all 36 outputs.
3. Coeffs -1 surround, 8 centre; centre pixel 0 surrounded by 255 -> -2040>>4 -> clamped 0. Centre coeff 127, others 0, pixel 255 -> 2024 -> clamped 255.
4. Ramp of scenario 1 with pix_valid one cycle in every 21 and start held high -> same 36 values, isolated out_valid pulses, frame_done once.
5. pix_valid=1 with start=0 for 10 cycles, then normal frame -> first 10 ignored; outputs identical to scenario 1.
6. rst for one cycle after 30 pixels, then a full ramp frame -> no out_valid after the reset edge until the new frame; kernel back to identity; outputs identical to scenario 1.
